// File: rtl/uart_sys_pkg.sv
// uart_sys_pkg: shared FIFO depth default and drain FSM encoding for the UART response path
package uart_sys_pkg;
  localparam int DEPTH_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_DONE = 2'd2} drain_st_t;
endpackage

// File: rtl/rsp_fifo_mem.sv
// rsp_fifo_mem: unreset register array with several write ports and one async read port
module rsp_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int NWP = 3,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic [NWP-1:0]            i_we,
  input  logic [NWP-1:0][AW-1:0]    i_wa,
  input  logic [NWP-1:0][WIDTH-1:0] i_wd,
  input  logic [AW-1:0]             i_ra,
  output logic [WIDTH-1:0]          o_rd
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  // write ports always target distinct addresses, so their order is irrelevant
  always_ff @(posedge clk)
    for (int p = 0; p < NWP; p++)
      if (i_we[p]) r_mem[i_wa[p]] <= i_wd[p];
  assign o_rd = r_mem[i_ra];
endmodule

// File: rtl/tx_rsp_queue.sv
// tx_rsp_queue: queues ALU/register-file response bytes and hands them one at a time to UART_TX
module tx_rsp_queue import uart_sys_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [15:0]              ALU_OUT,
  input  logic                     OUT_Valid,
  input  logic [WIDTH-1:0]         RdData,
  input  logic                     RdData_Valid,
  input  logic                     Busy,
  output logic [WIDTH-1:0]         TX_P_DATA,
  output logic                     TX_D_VLD,
  output logic [$clog2(DEPTH):0]   Level,
  output logic                     Full,
  output logic                     Overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  drain_st_t                 r_state;
  logic [AW-1:0]             r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]             r_level;
  logic [WIDTH-1:0]          r_tx_data;
  logic                      r_tx_vld, r_ovf;
  logic [LW-1:0]             w_free;
  logic                      w_pop, w_alu_ok, w_rd_ok, w_drop;
  logic [1:0]                w_n_push;
  logic [WIDTH-1:0]          w_head;
  logic [2:0]                w_we;
  logic [2:0][AW-1:0]        w_wa;
  logic [2:0][WIDTH-1:0]     w_wd;

  assign w_pop    = r_state == IDLE && r_level != '0 && !Busy;
  // a same-cycle pop frees its slot for this cycle's push
  assign w_free   = LW'(DEPTH) - r_level + LW'(w_pop);
  assign w_alu_ok = OUT_Valid && w_free >= LW'(2);
  assign w_rd_ok  = RdData_Valid && w_free >= (w_alu_ok ? LW'(3) : LW'(1));
  assign w_drop   = (OUT_Valid && !w_alu_ok) || (RdData_Valid && !w_rd_ok);
  assign w_n_push = {w_alu_ok, 1'b0} + {1'b0, w_rd_ok};
  assign w_we     = {w_rd_ok, w_alu_ok, w_alu_ok};
  assign w_wa     = {r_wr_ptr + (w_alu_ok ? AW'(2) : AW'(0)), r_wr_ptr + AW'(1), r_wr_ptr};
  assign w_wd     = {RdData, WIDTH'(ALU_OUT[15:8]), WIDTH'(ALU_OUT[7:0])};

  rsp_fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NWP(3)) u_mem (
    .clk  (CLK),
    .i_we (w_we),
    .i_wa (w_wa),
    .i_wd (w_wd),
    .i_ra (r_rd_ptr),
    .o_rd (w_head)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_n_push);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_level  <= r_level + LW'(w_n_push) - LW'(w_pop);
      r_ovf    <= w_drop;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_tx_data <= '0;
      r_tx_vld  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (w_pop) begin
          r_tx_data <= w_head;
          r_tx_vld  <= 1'b1;
          r_state   <= ISSUE;
        end
        ISSUE: if (Busy) begin
          r_tx_vld <= 1'b0;
          r_state  <= WAIT_DONE;
        end
        WAIT_DONE: if (!Busy) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign TX_P_DATA = r_tx_data;
  assign TX_D_VLD  = r_tx_vld;
  assign Level     = r_level;
  assign Full      = r_level == LW'(DEPTH);
  assign Overflow  = r_ovf;
endmodule

// File: tb/tb_tx_rsp_queue.sv
// tb_tx_rsp_queue: directed scenarios plus random traffic against a byte-queue reference model
module tb_tx_rsp_queue;
  localparam int DEPTH = 8;
  logic        clk = 0, rst = 1;
  logic [15:0] alu = '0;
  logic        ov = 0, rv = 0, busy = 0;
  logic [7:0]  rd = '0;
  logic [7:0]  tx_data;
  logic        tx_vld, full, ovf;
  logic [3:0]  level;
  int n_chk = 0, n_fail = 0;
  int mode = 0;
  byte unsigned exp_q[$];
  int m_lvl = 0, m_free = 0;
  bit m_out = 0, m_seen = 0, m_ovf = 0, m_pop = 0, m_aok = 0, m_rok = 0;
  logic prev_vld = 0;
  logic [7:0] prev_d = '0;
  int dly = 0, hold = 0;

  always #5 clk = ~clk;

  tx_rsp_queue #(.DEPTH(DEPTH), .WIDTH(8)) dut (
    .CLK(clk), .RST(rst), .ALU_OUT(alu), .OUT_Valid(ov), .RdData(rd), .RdData_Valid(rv),
    .Busy(busy), .TX_P_DATA(tx_data), .TX_D_VLD(tx_vld), .Level(level), .Full(full), .Overflow(ovf)
  );

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a byte queue, an occupancy count and a "byte in flight" flag cleared by a Busy rise+fall.
  always @(negedge clk) begin
    #1;
    chk("level", level, m_lvl);
    chk("full", full, m_lvl == DEPTH);
    chk("overflow", ovf, m_ovf);
    chk("tx_vld", tx_vld, m_out && !m_seen);
    if (rst) begin
      m_lvl = 0; m_out = 0; m_seen = 0; m_ovf = 0;
      exp_q.delete();
    end else begin
      m_pop  = !m_out && m_lvl > 0 && !busy;
      m_free = DEPTH - m_lvl + m_pop;
      m_aok  = ov && m_free >= 2;
      m_rok  = rv && m_free - (m_aok ? 2 : 0) >= 1;
      m_ovf  = (ov && !m_aok) || (rv && !m_rok);
      if (m_aok) begin exp_q.push_back(alu[7:0]); exp_q.push_back(alu[15:8]); end
      if (m_rok) exp_q.push_back(rd);
      m_lvl = m_lvl + (m_aok ? 2 : 0) + (m_rok ? 1 : 0) - (m_pop ? 1 : 0);
      if (m_pop) begin m_out = 1; m_seen = 0; end
      else if (m_out && !m_seen && busy) m_seen = 1;
      else if (m_out && m_seen && !busy) m_out = 0;
    end
  end

  always @(negedge clk) begin
    if (tx_vld && !prev_vld) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL spurious_tx: got %0h expected no byte at %0t", tx_data, $time);
      end else chk("tx_data", tx_data, exp_q.pop_front());
    end else if (tx_vld && prev_vld) chk("tx_stable", tx_data, prev_d);
    prev_vld = tx_vld;
    prev_d   = tx_data;
  end

  // UART_TX stand-in: mode 0 reacts to TX_D_VLD with random latency, 1 stuck busy, 2 never busy
  always @(posedge clk) begin
    #1;
    if (mode == 1) busy = 1;
    else if (mode == 2) busy = 0;
    else if (busy) begin hold--; if (hold <= 0) busy = 0; end
    else if (tx_vld) begin
      if (dly <= 0) begin
        busy = 1; hold = $urandom_range(1, 4); dly = $urandom_range(0, 3);
      end else dly--;
    end
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(bit o, logic [15:0] a, bit r, logic [7:0] d);
    ov = o; alu = a; rv = r; rd = d;
    tick(1);
    ov = 0; rv = 0;
  endtask

  initial begin
    tick(3); rst = 0; tick(2);
    push(1, 16'h1234, 0, 8'h00); tick(30);
    push(1, 16'hBEEF, 1, 8'h5A); tick(40);
    mode = 2; push(0, 16'h0, 1, 8'h77); push(0, 16'h0, 1, 8'h78); tick(25);
    mode = 0; tick(40);
    mode = 1; tick(3);
    repeat (3) push(1, 16'($urandom), 0, 8'h00);
    push(0, 16'h0, 1, 8'($urandom));
    push(1, 16'hDEAD, 0, 8'h00);
    push(0, 16'h0, 1, 8'hC3); tick(3);
    mode = 0; tick(150);
    for (int i = 0; i < 10; i++) begin push(0, 16'h0, 1, 8'(i)); tick(5); end
    tick(60);
    mode = 2;
    push(1, 16'($urandom), 0, 8'h00); push(1, 16'($urandom), 0, 8'h00); push(0, 16'h0, 1, 8'hA5); tick(3);
    rst = 1; ov = 1; rv = 1; alu = 16'h4444; rd = 8'h44; tick(1);
    rst = 0; ov = 0; rv = 0; mode = 0; tick(2);
    push(1, 16'h0F0E, 0, 8'h00); tick(40);
    repeat (400) begin
      ov = $urandom_range(0, 5) == 0; rv = $urandom_range(0, 5) == 0;
      alu = 16'($urandom); rd = 8'($urandom);
      tick(1);
    end
    ov = 0; rv = 0; tick(200);
    chk("queue_drained", exp_q.size(), 0);
    chk("final_level", level, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tx_rsp_queue.md
TX_RSP_QUEUE -- requirements
Module: tx_rsp_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning byte-FIFO entries (power of two, ≥4).
REQ-002 SHALL have parameter WIDTH, default 8, meaning byte width.
REQ-003 SHALL have port CLK  input  1  the single clock (REF_CLK domain).
REQ-004 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port ALU_OUT  input  16  ALU result.
REQ-006 SHALL have port OUT_Valid  input  1  one-cycle strobe qualifying ALU_OUT.
REQ-007 SHALL have port RdData  input  WIDTH  register-file read data.
REQ-008 SHALL have port RdData_Valid  input  1  one-cycle strobe qualifying RdData.
REQ-009 SHALL have port Busy  input  1  UART_TX busy, already synchronised to CLK.
REQ-010 SHALL have port TX_P_DATA  output  WIDTH  byte presented to the TX data synchroniser.
REQ-011 SHALL have port TX_D_VLD  output  1  level valid for TX_P_DATA.
REQ-012 SHALL have port Level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 SHALL have port Full  output  1  Level == DEPTH.
REQ-014 SHALL have port Overflow  output  1  one-cycle pulse when a response is dropped.

Function
REQ-015 On OUT_Valid, SHALL push 2 bytes: ALU_OUT[7:0] first, then ALU_OUT[15:8].
REQ-016 On RdData_Valid, SHALL push 1 byte RdData.
REQ-017 If both strobes occur in the same cycle, SHALL push the ALU bytes ahead of the RdData byte (3 bytes total).
REQ-018 All bytes of one cycle's push SHALL be written in that cycle and be visible in Level on the next cycle.
REQ-019 A response SHALL be pushed only if free space ≥ its byte count; otherwise the whole response is dropped, with no partial write.
REQ-020 On a simultaneous event with insufficient space for 3 bytes, the ALU response SHALL be kept if 2 bytes fit, and RdData dropped.
REQ-021 Any drop SHALL pulse Overflow for exactly one cycle.
REQ-022 Free space for the push check SHALL include any pop occurring in the same cycle.
REQ-023 Read/write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-024 The drain FSM SHALL have states IDLE, ISSUE and WAIT_DONE.
REQ-025 IDLE->ISSUE when Level>0 and Busy==0: pop the head byte into TX_P_DATA and assert TX_D_VLD the next cycle.
REQ-026 In ISSUE, SHALL hold TX_D_VLD=1 and TX_P_DATA stable until Busy==1 is sampled, then go to WAIT_DONE with TX_D_VLD=0 (this covers the slower TX clock).
REQ-027 WAIT_DONE->IDLE when Busy==0 is sampled.
REQ-028 At most one byte SHALL be outstanding; bytes SHALL leave in push order.
REQ-029 Push and pop in the same cycle SHALL update Level by (pushed − popped).

Reset
REQ-030 While RST is high at a CLK edge: pointers=0, Level=0, FSM=IDLE, TX_P_DATA=0, TX_D_VLD=0, Full=0, Overflow=0, and FIFO contents are don't-care.
REQ-031 A reset mid-transfer SHALL drop TX_D_VLD next cycle and discard all queued bytes, including strobes in the reset cycle.

Structure
REQ-032 DEPTH default and the FSM state encoding (2-bit: IDLE=0, ISSUE=1, WAIT_DONE=2) SHALL live in the shared package uart_sys_pkg.
REQ-033 Storage SHALL be a sub-module rsp_fifo_mem (multi-write-port register array, no reset on data).

Verification
REQ-034 Scenario: OUT_Valid with ALU_OUT=16'h1234, then Busy pulses per byte -> TX_P_DATA 8'h34 then 8'h12, with one TX_D_VLD assertion each.
REQ-035 Scenario: OUT_Valid=RdData_Valid=1, ALU_OUT=16'hBEEF, RdData=8'h5A -> bytes EF, BE, 5A in order, and Level=3 the next cycle.
REQ-036 Scenario: Busy held 0 after ISSUE for 20 cycles -> TX_D_VLD stays 1, data stable, and no second pop.
REQ-037 Scenario: fill to Level=7 with Busy stuck 1, then OUT_Valid -> Overflow pulse, Level stays 7; then RdData_Valid -> Level 8, Full=1.
REQ-038 Scenario: push 10 single bytes 00..09 while draining -> pointer wrap, output 00..09 in order, and no Overflow.
REQ-039 Scenario: RST asserted while in ISSUE with Level=4 -> next cycle TX_D_VLD=0 and Level=0, and the FSM restarts cleanly on new data.
